// File: rtl/multi_cycle_cpu_if.sv
// Memory-side bus of the multi-cycle core: instruction fetch port and data port,
// each with a req/ready handshake that tolerates any number of wait states.
interface multi_cycle_cpu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: IF/ID/EX/MEM/WB sequencing over handshaked
// instruction and data memories, with register file, ALU, retire counter and
// the single-cycle board debug ports.
module multi_cycle_cpu #(
  parameter logic [31:0] START_ADDR      = 32'd0,
  parameter bit          HALT_ON_INVALID = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  multi_cycle_cpu_if.master   bus,
  input  logic [4:0]          rf_addr,
  output logic [31:0]         rf_data,
  output logic [31:0]         cpu_pc,
  output logic [31:0]         cpu_inst,
  output logic [2:0]          cpu_state,
  output logic                halted,
  output logic [31:0]         retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_q;
  logic [31:0] mdr;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] gpr [0:31];

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] rd_a, rd_b;
  logic [31:0] alu_y;
  logic        inst_valid;
  logic        is_jr;
  logic        br_taken;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign sa       = ir[10:6];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jmp_tgt  = {pc[31:28], ir[25:0], 2'b00};
  assign is_jr    = (op == OP_RTYPE) && (funct == F_JR);
  assign br_taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  assign rd_a    = (rs == 5'd0) ? '0 : gpr[rs];
  assign rd_b    = (rt == 5'd0) ? '0 : gpr[rt];
  assign rf_data = (rf_addr == 5'd0) ? '0 : gpr[rf_addr];

  assign wb_dst  = (op == OP_RTYPE) ? rd : (op == OP_JAL) ? 5'd31 : rt;
  assign wb_data = (op == OP_LW) ? mdr : (op == OP_JAL) ? pc_plus4 : alu_q;

  // Requests are gated by resetn so a reset abandons a transfer immediately.
  assign bus.imem_req   = imem_req_q & resetn;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = dmem_req_q & resetn;
  assign bus.dmem_we    = dmem_we_q & resetn;
  assign bus.dmem_addr  = alu_q;
  assign bus.dmem_wdata = b_q;

  assign cpu_pc    = pc;
  assign cpu_inst  = ir;
  assign cpu_state = state;

  // Decode: flag every encoding outside the supported subset.
  always_comb begin
    inst_valid = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU, F_SUBU, F_SLT, F_SLTU, F_AND, F_NOR, F_OR, F_XOR,
          F_SLL, F_SRL, F_SRA, F_JR: inst_valid = 1'b1;
          default:                   inst_valid = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL:
        inst_valid = 1'b1;
      default: inst_valid = 1'b0;
    endcase
  end

  // ALU: operates on the A/B operands latched in ID.
  always_comb begin
    alu_y = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU:  alu_y = a_q + b_q;
          F_SUBU:  alu_y = a_q - b_q;
          F_SLT:   alu_y = {31'b0, ($signed(a_q) < $signed(b_q))};
          F_SLTU:  alu_y = {31'b0, (a_q < b_q)};
          F_AND:   alu_y = a_q & b_q;
          F_NOR:   alu_y = ~(a_q | b_q);
          F_OR:    alu_y = a_q | b_q;
          F_XOR:   alu_y = a_q ^ b_q;
          F_SLL:   alu_y = b_q << sa;
          F_SRL:   alu_y = b_q >> sa;
          F_SRA:   alu_y = $signed(b_q) >>> sa;
          default: alu_y = '0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_y = a_q + imm_sext;
      OP_LUI:                 alu_y = {imm, 16'h0000};
      default:                alu_y = '0;
    endcase
  end

  // Register file: single write port used only in WB; $0 is never written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (state == S_WB && wb_dst != 5'd0) begin
      gpr[wb_dst] <= wb_data;
    end
  end

  // Instruction sequencer with registered bus requests and retire counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IF;
      pc         <= START_ADDR;
      ir         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr        <= '0;
      retired    <= '0;
      halted     <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (bus.imem_ready) begin
            ir         <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state      <= S_ID;
          end
        end
        S_ID: begin
          a_q <= rd_a;
          b_q <= rd_b;
          if (!inst_valid) begin
            if (HALT_ON_INVALID) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc         <= pc_plus4;
              retired    <= retired + 32'd1;
              imem_req_q <= 1'b1;
              state      <= S_IF;
            end
          end else begin
            state <= S_EX;
          end
        end
        S_EX: begin
          alu_q <= alu_y;
          if (op == OP_BEQ || op == OP_BNE || op == OP_J || is_jr) begin
            if (op == OP_J)  pc <= jmp_tgt;
            else if (is_jr)  pc <= a_q;
            else             pc <= br_taken ? br_tgt : pc_plus4;
            retired    <= retired + 32'd1;
            imem_req_q <= 1'b1;
            state      <= S_IF;
          end else if (op == OP_LW || op == OP_SW) begin
            // Misaligned addresses take the invalid-instruction path.
            if (alu_y[1:0] != 2'b00) begin
              if (HALT_ON_INVALID) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                pc         <= pc_plus4;
                retired    <= retired + 32'd1;
                imem_req_q <= 1'b1;
                state      <= S_IF;
              end
            end else begin
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (op == OP_SW);
              state      <= S_MEM;
            end
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dmem_we_q) begin
              pc         <= pc_plus4;
              retired    <= retired + 32'd1;
              imem_req_q <= 1'b1;
              state      <= S_IF;
            end else begin
              mdr   <= bus.dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc         <= (op == OP_JAL) ? jmp_tgt : pc_plus4;
          retired    <= retired + 32'd1;
          imem_req_q <= 1'b1;
          state      <= S_IF;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Scoreboard bench for multi_cycle_cpu: directed programs with hand-computed
// retire results, store traffic, wait states, invalid handling and reset.
module tb_multi_cycle_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, resetn2;
  logic [4:0]  rf_addr, rf_addr2;
  logic [31:0] rf_data, cpu_pc, cpu_inst, retired;
  logic [31:0] rf_data2, cpu_pc2, cpu_inst2, retired2;
  logic [2:0]  cpu_state, cpu_state2;
  logic        halted, halted2;

  multi_cycle_cpu_if bus ();
  multi_cycle_cpu_if bus2 ();

  multi_cycle_cpu #(.START_ADDR(32'h0000_0100), .HALT_ON_INVALID(1'b1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .rf_addr(rf_addr), .rf_data(rf_data),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_state(cpu_state), .halted(halted),
    .retired(retired)
  );

  multi_cycle_cpu #(.START_ADDR(32'h0000_0000), .HALT_ON_INVALID(1'b0)) dut_nop (
    .clk(clk), .resetn(resetn2), .bus(bus2), .rf_addr(rf_addr2), .rf_data(rf_data2),
    .cpu_pc(cpu_pc2), .cpu_inst(cpu_inst2), .cpu_state(cpu_state2), .halted(halted2),
    .retired(retired2)
  );

  // Memory model for the main core: programmable wait states on each port.
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:63] = '{default: '0};
  int unsigned imem_wait, dmem_wait, iw_cnt, dw_cnt;

  assign bus.imem_ready = bus.imem_req && (iw_cnt == 0);
  assign bus.imem_rdata = imem[bus.imem_addr[11:2]];
  assign bus.dmem_ready = bus.dmem_req && (dw_cnt == 0);
  assign bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iw_cnt <= imem_wait;
      dw_cnt <= dmem_wait;
    end else begin
      if (bus.imem_req) iw_cnt <= (iw_cnt == 0) ? imem_wait : iw_cnt - 1;
      if (bus.dmem_req) dw_cnt <= (dw_cnt == 0) ? dmem_wait : dw_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (bus.dmem_req && bus.dmem_we && bus.dmem_ready)
      dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
  end

  // Second core: zero-wait memory holding invalid, addiu $1,$0,7, then a self-loop.
  function automatic logic [31:0] prog2(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hFC00_0000;
      32'h4:   return 32'h2401_0007;
      default: return 32'h1000_FFFF;
    endcase
  endfunction

  assign bus2.imem_ready = bus2.imem_req;
  assign bus2.imem_rdata = prog2(bus2.imem_addr);
  assign bus2.dmem_ready = bus2.dmem_req;
  assign bus2.dmem_rdata = '0;
  assign rf_addr2        = 5'd1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] v;
    int unsigned cyc;
  } ret_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  ret_t ret_q[$];
  st_t  st_q[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned dmem_hs = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_ret(input logic [31:0] pc, input logic [4:0] r,
                                   input logic [31:0] v, input int unsigned cyc);
    ret_t e;
    e.pc = pc; e.r = r; e.v = v; e.cyc = cyc;
    ret_q.push_back(e);
  endfunction

  // Monitor: pops expected stores and retires as the core presents them.
  initial begin : monitor
    logic [31:0] last;
    int unsigned cyc;
    ret_t e;
    st_t  s;
    last = '0;
    cyc = 0;
    rf_addr = 5'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last = '0;
        cyc = 0;
      end else begin
        cyc++;
        if (bus.dmem_req && bus.dmem_ready) dmem_hs++;
        if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
          if (st_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_store: addr %h data %h, none expected", bus.dmem_addr, bus.dmem_wdata);
          end else begin
            s = st_q.pop_front();
            chk("store_addr", bus.dmem_addr, s.a);
            chk("store_data", bus.dmem_wdata, s.d);
          end
        end
        if (retired != last) begin
          if (ret_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_retire: retired %h pc %h, none expected", retired, cpu_pc);
          end else begin
            e = ret_q.pop_front();
            chk("retire_count", retired, last + 32'd1);
            chk("retire_pc", cpu_pc, e.pc);
            chk("retire_cycles", 32'(cyc), 32'(e.cyc));
            rf_addr = e.r;
            #1;
            chk($sformatf("reg_r%0d", e.r), rf_data, e.v);
          end
          last = retired;
          cyc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus: four phases on the main core plus the NOP-on-invalid core.
  initial begin : stim
    int unsigned n, ireq, dreq;
    resetn = 1'b0;
    resetn2 = 1'b0;
    imem_wait = 0;
    dmem_wait = 2;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    imem[32'h100 >> 2] = 32'h2401_0005; // addiu $1,$0,5
    imem[32'h104 >> 2] = 32'h2402_0010; // addiu $2,$0,0x10
    imem[32'h108 >> 2] = 32'hAC41_0004; // sw   $1,4($2)
    imem[32'h10C >> 2] = 32'h8C43_0004; // lw   $3,4($2)
    imem[32'h110 >> 2] = 32'h1023_0001; // beq  $1,$3,+1
    imem[32'h114 >> 2] = 32'h2404_0099; // addiu $4,$0,0x99 (skipped)
    imem[32'h118 >> 2] = 32'h1421_0004; // bne  $1,$1,4
    imem[32'h11C >> 2] = 32'h0C00_0080; // jal  0x200
    imem[32'h120 >> 2] = 32'h8C4A_0003; // lw   $10,3($2) unaligned
    imem[32'h200 >> 2] = 32'h3C05_8000; // lui  $5,0x8000
    imem[32'h204 >> 2] = 32'h0005_3103; // sra  $6,$5,4
    imem[32'h208 >> 2] = 32'h0022_3823; // subu $7,$1,$2
    imem[32'h20C >> 2] = 32'h0027_402B; // sltu $8,$1,$7
    imem[32'h210 >> 2] = 32'h0027_482A; // slt  $9,$1,$7
    imem[32'h214 >> 2] = 32'h03E0_0008; // jr   $31

    push_ret(32'h104, 5'd1,  32'h5,          4);
    push_ret(32'h108, 5'd2,  32'h10,         4);
    push_ret(32'h10C, 5'd1,  32'h5,          6);
    push_ret(32'h110, 5'd3,  32'h5,          7);
    push_ret(32'h118, 5'd3,  32'h5,          3);
    push_ret(32'h11C, 5'd4,  32'h0,          3);
    push_ret(32'h200, 5'd31, 32'h120,        4);
    push_ret(32'h204, 5'd5,  32'h8000_0000,  4);
    push_ret(32'h208, 5'd6,  32'hF800_0000,  4);
    push_ret(32'h20C, 5'd7,  32'hFFFF_FFF5,  4);
    push_ret(32'h210, 5'd8,  32'h1,          4);
    push_ret(32'h214, 5'd9,  32'h0,          4);
    push_ret(32'h120, 5'd31, 32'h120,        3);
    begin
      st_t s;
      s.a = 32'h14; s.d = 32'h5;
      st_q.push_back(s);
    end

    // Phase 1: reset values, then the full program until the unaligned lw halts.
    repeat (3) @(negedge clk);
    chk("reset_pc", cpu_pc, 32'h100);
    chk("reset_state", 32'(cpu_state), 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_ir", cpu_inst, 32'd0);
    chk("reset_imem_req", 32'(bus.imem_req), 32'd0);
    chk("reset_dmem_req", 32'(bus.dmem_req), 32'd0);
    #1 resetn = 1'b1;
    #1;
    chk("first_imem_req", 32'(bus.imem_req), 32'd1);
    chk("first_imem_addr", bus.imem_addr, 32'h100);
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    chk("halt_state", 32'(cpu_state), 32'd5);
    chk("halt_retired", retired, 32'd13);
    chk("halt_pc", cpu_pc, 32'h120);
    ireq = 0; dreq = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.imem_req) ireq++;
      if (bus.dmem_req) dreq++;
    end
    chk("halt_no_imem_req", 32'(ireq), 32'd0);
    chk("halt_no_dmem_req", 32'(dreq), 32'd0);
    chk("unaligned_dmem_handshakes", 32'(dmem_hs), 32'd2);
    chk("stored_word", dmem[5], 32'h5);
    chk("retire_queue_drained", 32'(ret_q.size()), 32'd0);
    chk("store_queue_drained", 32'(st_q.size()), 32'd0);

    // Phase 2: three fetch wait states on the first addiu.
    imem_wait = 3;
    resetn = 1'b0;
    push_ret(32'h104, 5'd1, 32'h5, 7);
    @(negedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_imem_req", 32'(bus.imem_req), 32'd1);
      chk("wait_imem_addr", bus.imem_addr, 32'h100);
      chk("wait_state", 32'(cpu_state), 32'd0);
    end
    n = 0;
    while (retired != 32'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_retired", retired, 32'd1);
    @(negedge clk);
    chk("wait_queue_drained", 32'(ret_q.size()), 32'd0);

    // Phase 3: invalid opcode, halting core and NOP-retiring core side by side.
    imem_wait = 0;
    resetn = 1'b0;
    imem[32'h100 >> 2] = 32'hFC00_0000;
    @(negedge clk);
    #1;
    resetn = 1'b1;
    resetn2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("nop_retired", retired2, 32'd1);
    chk("nop_pc", cpu_pc2, 32'h4);
    chk("nop_halted", 32'(halted2), 32'd0);
    @(negedge clk);
    chk("inv_halted", 32'(halted), 32'd1);
    chk("inv_state", 32'(cpu_state), 32'd5);
    chk("inv_retired", retired, 32'd0);
    ireq = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.imem_req) ireq++;
    end
    chk("nop_next_retired", retired2, 32'd2);
    chk("nop_next_pc", cpu_pc2, 32'h8);
    chk("nop_next_r1", rf_data2, 32'h7);
    chk("inv_no_imem_req", 32'(ireq), 32'd0);
    chk("inv_retired_hold", retired, 32'd0);
    resetn2 = 1'b0;

    // Phase 4: reset asserted while a store waits in MEM.
    dmem_wait = 20;
    resetn = 1'b0;
    imem[32'h100 >> 2] = 32'hAC00_0004; // sw $0,4($0)
    @(negedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_state", 32'(cpu_state), 32'd3);
    chk("mid_dmem_req", 32'(bus.dmem_req), 32'd1);
    chk("mid_dmem_we", 32'(bus.dmem_we), 32'd1);
    chk("mid_dmem_addr", bus.dmem_addr, 32'h4);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("abort_dmem_we", 32'(bus.dmem_we), 32'd0);
    chk("abort_pc", cpu_pc, 32'h100);
    chk("abort_state", 32'(cpu_state), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_write", dmem[1], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
